uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLK_FREQ, 27_000_000, system clock frequency in Hz.
REQ-002 Parameter: BAUD_RATE, 115200, serial bit rate in bit/s.
REQ-003 Port: clk  input  1  system clock; all logic on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: rx_pin  input  1  asynchronous serial line; idle high.
REQ-006 Port: rx_data  output  8  received byte; stable while rx_valid is high.
REQ-007 Port: rx_valid  output  1  holding register full.
REQ-008 Port: rx_ready  input  1  consumer accepts rx_data when high with rx_valid.
REQ-009 Port: frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 Port: overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Function
REQ-011 Frame format SHALL be START(0), B0..B7 (LSB first), STOP(1); no parity.
REQ-012 Bit period SHALL be CYCLE = floor(CLK_FREQ/BAUD_RATE) clocks (234 at defaults); counter width SHALL be ceil(log2(CYCLE)) bits.
REQ-013 rx_pin SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value (rx_s).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-015 IDLE: rx_s == 0 -> START; counter cleared.
REQ-016 START: at counter == CYCLE/2-1, sample rx_s; 1 -> IDLE (glitch rejected, no output); 0 -> DATA, counter cleared, bit index 0.
REQ-017 DATA: at counter == CYCLE-1, sample rx_s into shift position bit index, clear counter; after bit 7 -> STOP.
REQ-018 STOP: at counter == CYCLE-1, sample rx_s; 1 -> deliver byte, -> IDLE; 0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_s == 1, then -> IDLE.
REQ-020 Delivery: rx_data and rx_valid SHALL update on the clock after the stop sample (1-cycle latency from stop sample).
REQ-021 Handshake: rx_valid && rx_ready clears rx_valid next cycle; rx_data holds its value until the next delivery.
REQ-022 Delivery with rx_valid high and no same-cycle handshake: new byte dropped, overrun pulse, rx_data/rx_valid unchanged.
REQ-023 Delivery in the same cycle as a handshake: new byte loaded, rx_valid stays high, no overrun.
REQ-024 frame_err and overrun SHALL be high for exactly one clock per event.

Reset
REQ-025 Asserting rst_n low SHALL immediately force: state IDLE, counter 0, bit index 0, shift register 0, rx_data 8'h00, rx_valid 0, frame_err 0, overrun 0, synchronizer FFs 1.
REQ-026 Reset mid-frame SHALL abandon the frame; after release, the first falling edge on rx_s starts a new frame.

Structure
REQ-027 Package uart_pkg SHALL hold the CYCLE computation and the frame constants (data bits 8, stop bits 1) shared with uart_tx.
REQ-028 The 2-FF synchronizer SHALL be a sub-module sync_2ff (reset value parameterised, here 1).
REQ-029 FSM, counters and holding register SHALL be in uart_rx; no other sub-modules.

Verification
REQ-030 Frame 0x55 at 234 clk/bit, rx_ready held 1 -> rx_data 0x55, rx_valid one cycle, no error pulses.
REQ-031 Back-to-back frames 0x00 then 0xFF, no idle gap, rx_ready 1 -> two deliveries 0x00, 0xFF in order.
REQ-032 rx_pin low for 50 clk then high -> no rx_valid, no frame_err, FSM back in IDLE.
REQ-033 Frame 0xA3 with stop bit driven 0 -> frame_err pulse, rx_valid stays 0; line then high -> next frame 0x3C received correctly.
REQ-034 Frames 0x11 then 0x22 with rx_ready 0 -> rx_data 0x11, rx_valid 1, overrun pulse at second delivery; rx_ready 1 then clears rx_valid.
REQ-035 rst_n pulsed low during bit 4 of a frame -> all outputs at reset values; following frame 0x7E received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants, bit-period helper and receiver state type
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } rx_state_t;

    // Clocks per serial bit, truncated toward zero.
    function automatic int calc_cycle(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with parameterised reset value
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with a one-entry holding register and error pulses
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 27_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CYCLE = calc_cycle(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = $clog2(CYCLE);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CYCLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic w_rx_s;

    rx_state_t              r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_done;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  (rx_pin),
        .o_q  (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                // Mid-start-bit recheck filters out short low glitches.
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_rx_s;
                        if (r_bit_idx == IDX_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A same-cycle handshake frees the slot, so the new byte is taken.
            if (r_done) begin
                if (!r_valid || rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
